// File: rtl/timekeeper_ssd.sv
// 24-hour BCD timekeeper with 12/24-hour display, set-time mode and a multiplexed active-low 7-segment driver.
// Latency: time/digit_sel/sec_tick change on the tick/scan edge; AN, ssd and pm follow one cycle later.
// Backpressure: none, free-running; define TIMEKEEPER_SSD_SET_BLINK_EN to blink hour/minute digits in set mode.
module timekeeper_ssd #(
    parameter int CLK_HZ  = 100000000,
    parameter int SCAN_HZ = 1000,
    parameter int NUM_AN  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mode_12h,
    input  logic              set_en,
    input  logic              inc_hr,
    input  logic              inc_min,
    output logic [NUM_AN-1:0] AN,
    output logic [6:0]        ssd,
    output logic              pm,
    output logic              sec_tick,
    output logic [2:0]        digit_sel,
    output logic [23:0]       time_bcd
);

    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int TW       = $clog2(CLK_HZ);
    localparam int SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_HZ - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [2:0]    DIG_LAST  = 3'(NUM_AN - 1);

    logic [TW-1:0]     r_tick_cnt;
    logic              r_sec_tick;
    logic              r_set_d;
    logic [7:0]        r_hr;
    logic [7:0]        r_min;
    logic [7:0]        r_sec;
    logic [SW-1:0]     r_scan_cnt;
    logic [2:0]        r_digit_sel;
    logic [NUM_AN-1:0] r_an;
    logic [6:0]        r_ssd;
    logic              r_pm;

    logic              w_set_fall;
    logic              w_tick;
    logic              w_blink;
    logic [4:0]        w_hr_bin;
    logic [4:0]        w_disp_bin;
    logic [3:0]        w_hr_tens;
    logic [3:0]        w_hr_ones;
    logic [3:0]        w_digit;
    logic [NUM_AN-1:0] w_an;
    logic [6:0]        w_ssd;

    // BCD 00..59 increment with wrap, no carry out
    function automatic logic [7:0] inc_mod60(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // BCD 00..23 increment with wrap
    function automatic logic [7:0] inc_hour(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h23) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Active-low segments a..g on bits 6..0
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Releasing set mode restarts the second so the first increment is a full period later;
    // that restart also swallows a tick that would have landed on the same edge.
    assign w_set_fall = r_set_d & ~set_en;
    assign w_tick     = (r_tick_cnt == TICK_LAST) && !w_set_fall;

`ifdef TIMEKEEPER_SSD_SET_BLINK_EN
    localparam logic [TW-1:0] TICK_HALF = TW'(CLK_HZ / 2);
    assign w_blink = set_en && (r_tick_cnt >= TICK_HALF);
`else
    assign w_blink = 1'b0;
`endif

    // Tick counter, seconds pulse and the time-of-day registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_sec_tick <= 1'b0;
            r_set_d    <= 1'b0;
            r_hr       <= 8'h00;
            r_min      <= 8'h00;
            r_sec      <= 8'h00;
        end else begin
            r_set_d    <= set_en;
            r_sec_tick <= w_tick;
            if (w_set_fall || (r_tick_cnt == TICK_LAST)) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
            if (set_en) begin
                r_sec <= 8'h00;
                if (inc_min) begin
                    r_min <= inc_mod60(r_min);
                end
                if (inc_hr) begin
                    r_hr <= inc_hour(r_hr);
                end
            end else if (w_tick) begin
                r_sec <= inc_mod60(r_sec);
                if (r_sec == 8'h59) begin
                    r_min <= inc_mod60(r_min);
                    if (r_min == 8'h59) begin
                        r_hr <= inc_hour(r_hr);
                    end
                end
            end
        end
    end

    // Scan divider and digit index
    always_ff @(posedge clock) begin
        if (reset) begin
            r_scan_cnt  <= '0;
            r_digit_sel <= 3'd0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt  <= '0;
            r_digit_sel <= (r_digit_sel == DIG_LAST) ? 3'd0 : r_digit_sel + 3'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // Display hour digits: 24-hour BCD passes through, 12-hour maps 0->12 and 13..23 -> 1..11
    always_comb begin
        w_hr_bin   = 5'(r_hr[7:4]) * 5'd10 + 5'(r_hr[3:0]);
        w_disp_bin = w_hr_bin;
        if (w_hr_bin == 5'd0) begin
            w_disp_bin = 5'd12;
        end else if (w_hr_bin > 5'd12) begin
            w_disp_bin = w_hr_bin - 5'd12;
        end
        if (mode_12h) begin
            w_hr_tens = (w_disp_bin >= 5'd10) ? 4'd1 : 4'd0;
            w_hr_ones = (w_disp_bin >= 5'd10) ? 4'(w_disp_bin - 5'd10) : 4'(w_disp_bin);
        end else begin
            w_hr_tens = r_hr[7:4];
            w_hr_ones = r_hr[3:0];
        end
    end

    // Select the scanned digit and form next anode/segment values
    always_comb begin
        w_an    = '1;
        w_ssd   = 7'b1111111;
        w_digit = 4'd0;
        case (r_digit_sel)
            3'd0:    w_digit = r_sec[3:0];
            3'd1:    w_digit = r_sec[7:4];
            3'd2:    w_digit = r_min[3:0];
            3'd3:    w_digit = r_min[7:4];
            3'd4:    w_digit = w_hr_ones;
            3'd5:    w_digit = w_hr_tens;
            default: w_digit = 4'd0;
        endcase
        if (r_digit_sel < 3'd6) begin
            w_an[r_digit_sel] = 1'b0;
            w_ssd = seg7(w_digit);
            if ((r_digit_sel == 3'd5) && mode_12h && (w_hr_tens == 4'd0)) begin
                w_ssd = 7'b1111111;
            end
            if (w_blink && (r_digit_sel >= 3'd2)) begin
                w_ssd = 7'b1111111;
            end
        end
    end

    // Register anode, segments and pm together so they never disagree
    always_ff @(posedge clock) begin
        if (reset) begin
            r_an  <= '1;
            r_ssd <= 7'b1111111;
            r_pm  <= 1'b0;
        end else begin
            r_an  <= w_an;
            r_ssd <= w_ssd;
            r_pm  <= (r_hr >= 8'h12);
        end
    end

    assign AN        = r_an;
    assign ssd       = r_ssd;
    assign pm        = r_pm;
    assign sec_tick  = r_sec_tick;
    assign digit_sel = r_digit_sel;
    assign time_bcd  = {r_hr, r_min, r_sec};

endmodule

// File: tb/tb_timekeeper_ssd.sv
// Bench for timekeeper_ssd: directed scenarios plus random stimulus against a seconds-of-day model.
// Checks every cycle on the falling clock edge; two instances cover 8 and 6 anodes.
// No flow control on this block.
module tb_timekeeper_ssd;

    localparam int CLK_HZ   = 10;
    localparam int SCAN_HZ  = 5;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mode_12h = 1'b0;
    logic        set_en = 1'b0;
    logic        inc_hr = 1'b0;
    logic        inc_min = 1'b0;
    logic [7:0]  AN8;
    logic [6:0]  ssd;
    logic        pm;
    logic        sec_tick;
    logic [2:0]  digit_sel;
    logic [23:0] time_bcd;
    logic [5:0]  an6;
    logic [6:0]  ssd6;
    logic        pm6;
    logic        sec_tick6;
    logic [2:0]  dsel6;
    logic [23:0] time6;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    logic [6:0] SEG [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    timekeeper_ssd #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .NUM_AN(8)) u_dut (
        .clock(clock), .reset(reset), .mode_12h(mode_12h), .set_en(set_en),
        .inc_hr(inc_hr), .inc_min(inc_min), .AN(AN8), .ssd(ssd), .pm(pm),
        .sec_tick(sec_tick), .digit_sel(digit_sel), .time_bcd(time_bcd));

    timekeeper_ssd #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .NUM_AN(6)) u_dut6 (
        .clock(clock), .reset(reset), .mode_12h(mode_12h), .set_en(set_en),
        .inc_hr(inc_hr), .inc_min(inc_min), .AN(an6), .ssd(ssd6), .pm(pm6),
        .sec_tick(sec_tick6), .digit_sel(dsel6), .time_bcd(time6));

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_tod = 0;      // seconds since midnight
    int         m_tick = 0;
    bit         m_stick = 0;
    bit         m_set_prev = 0;
    int         m_scan = 0;
    int         m_sel = 0;
    int         m_sel6 = 0;
    logic [7:0] e_an = 8'hFF;
    logic [6:0] e_ssd = 7'h7F;
    logic [5:0] e_an6 = 6'h3F;
    logic [6:0] e_ssd6 = 7'h7F;
    bit         e_pm = 0;
    logic [7:0] t_an;
    logic [6:0] t_sg;
    bit         t_blink, t_fall, t_tick;
    int         t_hr, t_mn;

    function automatic logic [23:0] to_bcd(input int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic disp(input int tod, input int sel, input bit m12, input bit blink,
                        output logic [7:0] an, output logic [6:0] sg);
        int hr, mn, sc, hd, d;
        hr = tod / 3600;
        mn = (tod / 60) % 60;
        sc = tod % 60;
        hd = m12 ? (((hr % 12) == 0) ? 12 : hr % 12) : hr;
        an = 8'hFF;
        sg = 7'h7F;
        if (sel < 6) begin
            an[3'(sel)] = 1'b0;
            case (sel)
                0:       d = sc % 10;
                1:       d = sc / 10;
                2:       d = mn % 10;
                3:       d = mn / 10;
                4:       d = hd % 10;
                default: d = hd / 10;
            endcase
            sg = SEG[d];
            if (sel == 5 && m12 && hd < 10) sg = 7'h7F;
            if (blink && sel >= 2) sg = 7'h7F;
        end
    endtask

    always @(posedge clock) begin
        if (reset) begin
            m_tod = 0; m_tick = 0; m_stick = 0; m_set_prev = 0;
            m_scan = 0; m_sel = 0; m_sel6 = 0;
            e_an = 8'hFF; e_ssd = 7'h7F; e_an6 = 6'h3F; e_ssd6 = 7'h7F; e_pm = 0;
        end else begin
            t_blink = 1'b0;
`ifdef TIMEKEEPER_SSD_SET_BLINK_EN
            t_blink = set_en && (m_tick >= CLK_HZ / 2);
`endif
            disp(m_tod, m_sel, mode_12h, t_blink, t_an, t_sg);
            e_an = t_an; e_ssd = t_sg;
            disp(m_tod, m_sel6, mode_12h, t_blink, t_an, t_sg);
            e_an6 = t_an[5:0]; e_ssd6 = t_sg;
            e_pm = (m_tod >= 12 * 3600);
            t_fall = m_set_prev && !set_en;
            t_tick = (m_tick == CLK_HZ - 1) && !t_fall;
            m_tick = (t_fall || m_tick == CLK_HZ - 1) ? 0 : m_tick + 1;
            m_stick = t_tick;
            m_set_prev = set_en;
            if (set_en) begin
                t_hr = m_tod / 3600;
                t_mn = (m_tod / 60) % 60;
                if (inc_min) t_mn = (t_mn + 1) % 60;
                if (inc_hr)  t_hr = (t_hr + 1) % 24;
                m_tod = t_hr * 3600 + t_mn * 60;
            end else if (t_tick) begin
                m_tod = (m_tod + 1) % 86400;
            end
            if (m_scan == SCAN_DIV - 1) begin
                m_scan = 0;
                m_sel  = (m_sel + 1) % 8;
                m_sel6 = (m_sel6 + 1) % 6;
            end else begin
                m_scan++;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (chk_en) begin
            check("time_bcd", time_bcd, to_bcd(m_tod));
            check("sec_tick", sec_tick, m_stick);
            check("digit_sel", digit_sel, m_sel);
            check("AN", AN8, e_an);
            check("ssd", ssd, e_ssd);
            check("pm", pm, e_pm);
            check("digit_sel6", dsel6, m_sel6);
            check("AN6", an6, e_an6);
            check("ssd6", ssd6, e_ssd6);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic pulse(input bit h, input bit m);
        step();
        inc_hr = h; inc_min = m;
        step();
        inc_hr = 1'b0; inc_min = 1'b0;
    endtask

    task automatic wait_tick(input int bound);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!sec_tick && n < bound);
        if (!sec_tick) begin
            n_checks++; n_err++;
            $display("FAIL wait_tick: no sec_tick within %0d cycles", bound);
        end
    endtask

    task automatic wait_an(input logic [7:0] val, input int bound);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (AN8 !== val && n < bound);
        if (AN8 !== val) begin
            n_checks++; n_err++;
            $display("FAIL wait_an: AN %0h never reached %0h", AN8, val);
        end
    endtask

    task automatic wait_an6(input logic [5:0] val, input int bound);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (an6 !== val && n < bound);
        if (an6 !== val) begin
            n_checks++; n_err++;
            $display("FAIL wait_an6: AN %0h never reached %0h", an6, val);
        end
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    logic [7:0] seq8 [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hFF, 8'hFF};
    logic [5:0] seq6 [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

    initial begin
        int n;
        // 1: reset state and first tick
        @(negedge clock);
        chk_en = 1'b1;
        repeat (2) @(negedge clock);
        check("reset_AN", AN8, 8'hFF);
        check("reset_ssd", ssd, 7'h7F);
        check("reset_time", time_bcd, 24'h000000);
        check("reset_pm", pm, 1'b0);
        #1 reset = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!sec_tick && n < 30);
        check("first_tick_cycles", n, 10);
        check("first_tick_time", time_bcd, 24'h000001);

        // 2: set 23:59, release, run 60 seconds through midnight
        step();
        set_en = 1'b1;
        for (int i = 0; i < 23; i++) pulse(1'b1, 1'b0);
        for (int i = 0; i < 59; i++) pulse(1'b0, 1'b1);
        check("set_2359", time_bcd, 24'h235900);
        set_en = 1'b0;
        for (int i = 0; i < 59; i++) wait_tick(2 * CLK_HZ);
        check("run_235959", time_bcd, 24'h235959);
        check("pm_before", pm, 1'b1);
        wait_tick(2 * CLK_HZ);
        check("run_midnight", time_bcd, 24'h000000);
        @(negedge clock);
        check("pm_after", pm, 1'b0);

        // 3: 12-hour display of hour 00 and 13
        #1 mode_12h = 1'b1;
        wait_an(8'hEF, 40);
        check("h12_00_h0", ssd, 7'b0010010);
        check("h12_00_pm", pm, 1'b0);
        wait_an(8'hDF, 40);
        check("h12_00_h1", ssd, 7'b1001111);
        step();
        set_en = 1'b1;
        for (int i = 0; i < 13; i++) pulse(1'b1, 1'b0);
        set_en = 1'b0;
        wait_an(8'hDF, 40);
        check("h12_13_h1_blank", ssd, 7'h7F);
        wait_an(8'hEF, 40);
        check("h12_13_h0", ssd, 7'b1001111);
        check("h12_13_pm", pm, 1'b1);

        // 4: simultaneous increments at 23:59 and ignored run-mode increments
        do_reset();
        mode_12h = 1'b0;
        set_en = 1'b1;
        for (int i = 0; i < 23; i++) pulse(1'b1, 1'b0);
        for (int i = 0; i < 59; i++) pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b1);
        check("both_inc_wrap", time_bcd, 24'h000000);
        set_en = 1'b0;
        pulse(1'b1, 1'b1);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        check("run_inc_ignored", time_bcd[23:8], 16'h0000);

        // 5: anode scan sequences for 8 and 6 anodes
        wait_an(8'hFF, 40);
        wait_an(8'hFE, 40);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clock);
            check("scan8", AN8, seq8[(k / 2) % 8]);
        end
        wait_an6(6'h1F, 40);
        wait_an6(6'h3E, 40);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clock);
            check("scan6", an6, seq6[(k / 2) % 6]);
        end

        // 6: reset in the tick cycle at 12:34:56
        do_reset();
        set_en = 1'b1;
        for (int i = 0; i < 12; i++) pulse(1'b1, 1'b0);
        for (int i = 0; i < 34; i++) pulse(1'b0, 1'b1);
        set_en = 1'b0;
        for (int i = 0; i < 56; i++) wait_tick(2 * CLK_HZ);
        check("reach_123456", time_bcd, 24'h123456);
        repeat (9) @(negedge clock);
        check("hold_123456", time_bcd, 24'h123456);
        #1 reset = 1'b1;
        @(negedge clock);
        check("reset_on_tick_time", time_bcd, 24'h000000);
        check("reset_on_tick_stick", sec_tick, 1'b0);
        #1 reset = 1'b0;

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            step();
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 39) == 0) set_en = !set_en;
            if ($urandom_range(0, 99) == 0) mode_12h = !mode_12h;
            inc_hr  = ($urandom_range(0, 3) == 0);
            inc_min = ($urandom_range(0, 2) == 0);
        end
        step();
        reset = 1'b0; set_en = 1'b0; inc_hr = 1'b0; inc_min = 1'b0;
        repeat (4) @(negedge clock);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/timekeeper_ssd.md
Name: timekeeper_ssd

Overview:
Parametrised 24-hour BCD timekeeper with a multiplexed, active-low 7-segment display driver. It adds run-time 12/24-hour display mode, a set-time mode with hour/minute increment inputs, and leading-zero blanking. All logic runs on the single system clock using clock-enable ticks; no derived clocks are used. It sits between the debounced board buttons and the board's anode and segment pins.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz; 1 Hz tick period = CLK_HZ cycles (CLK_HZ >= 4, even).
SCAN_HZ, 1000, digit advance rate; scan period = CLK_HZ/SCAN_HZ cycles (>= 1).
NUM_AN, 8, number of anodes driven (6..8).

Ports:
clock  in  1  system clock; all state updates on its rising edge.
reset  in  1  synchronous, active-high reset.
mode_12h  in  1  1 = 12-hour display, 0 = 24-hour display; display only, internal time is always 24-hour.
set_en  in  1  set-time mode while high.
inc_hr  in  1  one-cycle pulse (debounced upstream): hour +1.
inc_min  in  1  one-cycle pulse: minute +1.
AN  out  NUM_AN  anodes, active-low, one-hot or all ones.
ssd  out  7  segments, active-low.
pm  out  1  1 when internal hour >= 12.
sec_tick  out  1  one-cycle pulse on each 1 Hz tick.
digit_sel  out  3  current scan index.
time_bcd  out  24  {h1,h0,m1,m0,s1,s0}, four bits each.

Behaviour:
- Reset (synchronous, dominant over all other inputs in the same cycle):
  - time 00:00:00, tick counter 0, scan counter 0, digit_sel 0.
  - AN all ones, ssd 7'b1111111, pm 0, sec_tick 0.
- Tick counter:
  - Counts 0..CLK_HZ-1 and wraps.
  - sec_tick = 1 for the cycle in which the count equals CLK_HZ-1.
  - sec_tick is registered and coincides with the seconds update.
- Run mode (set_en = 0): on a tick, BCD increment with carry.
  - s0 9->0 carries to s1; s1 5->0 carries to m0; m0 9->0 carries to m1; m1 5->0 carries to hour.
  - Hour 23->00; h0 9->0 carries to h1 when h1 < 2.
  - inc_hr and inc_min are ignored in run mode.
- Set mode (set_en = 1):
  - Seconds are forced to 00; ticks do not advance time; the tick counter keeps running and sec_tick still pulses.
  - inc_min: minute +1, 59->00, no carry into hour.
  - inc_hr: hour +1, 23->00.
  - Both pulses in the same cycle: both apply independently.
- set_en falling edge (registered compare): tick counter cleared to 0, so the first seconds increment occurs CLK_HZ cycles after release.
- pm is combinational from the internal hour, then registered with the display outputs.
- Scan:
  - Scan counter counts 0..CLK_HZ/SCAN_HZ-1; at terminal count, digit_sel advances 0..NUM_AN-1, then wraps to 0.
- Digit mapping:
  - Index 0..5 maps to s0, s1, m0, m1, h0, h1.
  - Index >= 6 is blank: AN all ones.
  - Otherwise AN has bit[digit_sel] = 0 and all other bits 1.
- 12-hour mode display hour:
  - 0 -> 12, 1..12 -> unchanged, 13..23 -> hour-12.
  - Hour tens digit blanked (AN for that digit stays low, ssd = 7'b1111111) when it is 0.
- 24-hour mode: no blanking.
- Segment encoding, bit6..bit0 = a..g, active-low:
  - 0: 0000001, 1: 1001111, 2: 0010010, 3: 0000110, 4: 1001100
  - 5: 0100100, 6: 0100000, 7: 0001111, 8: 0000000, 9: 0000100
  - Codes 10..15 are not reachable.
- AN, ssd and pm are registered with one-cycle latency from the digit_sel and time update. They never show a mixed digit/anode state.

Optional Feature:
Macro TIMEKEEPER_SSD_SET_BLINK_EN.
- Defined: while set_en = 1, the four hour and minute digits show ssd = 7'b1111111 whenever the tick counter >= CLK_HZ/2. The result is a 1 Hz, 50% blink; seconds digits do not blink.
- Not defined: there is no blink and digits display normally in set mode.
- Time-keeping is identical in both builds.

Test Plan:
1. CLK_HZ=10, SCAN_HZ=5. Assert reset 3 cycles -> AN=8'hFF, ssd=7'h7F, time_bcd=24'h000000. First sec_tick 10 cycles after release; time_bcd=24'h000001.
2. Set mode: 23 inc_hr and 59 inc_min pulses, release set_en, run 60 ticks -> time_bcd=24'h235959 then 24'h000000; pm goes 1->0.
3. mode_12h=1: hour 00 -> digits h1/h0 show 1,2 with pm=0. Hour 13 -> h1 blank (ssd=7'h7F, AN[5]=0), h0=1, pm=1.
4. Set mode at 23:59: single cycle with inc_hr and inc_min together -> 00:00. Run-mode inc pulses -> time unchanged.
5. Scan: AN sequence FE,FD,FB,F7,EF,DF,FF,FF with each step 2 cycles, wrapping. NUM_AN=6 -> wraps to 3F-masked FE after DF.
6. Assert reset in the sec_tick cycle at 12:34:56 -> time_bcd=24'h000000 next cycle, no increment. With the blink macro defined, hour/minute ssd=7'h7F in cycles 5..9 of each tick period.
